// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer -- parallel-in / serial-out shifter with valid/ready load.
//
// A word accepted on load_valid && load_ready is emitted one bit per clk
// cycle on sout, starting the cycle after acceptance. A new word can be
// accepted on the final bit cycle, so frames can run back to back with no gap.
//
// Optional feature macro: PISO_PARITY_EN
//   defined   : one even-parity bit follows the data bits (frame = WIDTH+1)
//   undefined : no parity state or logic (frame = WIDTH)
//
// Parameters
//   WIDTH       parallel word width (>= 2)
//   LSB_FIRST   0: bit WIDTH-1 first, 1: bit 0 first
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high reset
//   load_valid   in   parallel word offered
//   load_ready   out  word accepted this cycle if load_valid
//   load_data    in   parallel word [WIDTH-1:0]
//   sout         out  serial bit (registered)
//   sout_valid   out  sout carries a frame bit
//   frame_start  out  first bit of a frame
//   frame_last   out  final bit of a frame
//   busy         out  state is not IDLE
//
// state  | meaning
// IDLE   | no frame in flight, ready for a word
// SHIFT  | data bits on sout, bit_cnt_q = index of the bit now on sout
// PARITY | parity bit on sout (only with PISO_PARITY_EN)
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(WIDTH - 2);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             sout_q;
    logic             sout_valid_q;
    logic             frame_start_q;
    logic             frame_last_q;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    logic             accept;
    logic             load_first_d;
    logic [WIDTH-1:0] load_rest_d;
    logic             shift_first_d;
    logic [WIDTH-1:0] shift_rest_d;

    // The shift register holds only the bits not yet presented; the bit
    // going onto sout next is always at the "first" end of it.
    always_comb begin
        load_first_d  = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
        load_rest_d   = LSB_FIRST ? (load_data >> 1) : (load_data << 1);
        shift_first_d = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
        shift_rest_d  = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
    end

    // Ready in IDLE or on the final bit cycle, which is what allows
    // gap-free back-to-back frames.
    assign load_ready = !reset && ((state_q == IDLE) || frame_last_q);
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else if (accept) begin
            // accept only happens in IDLE or on a final bit, so starting a
            // new frame here never truncates one in flight
            state_q       <= SHIFT;
            shreg_q       <= load_rest_d;
            bit_cnt_q     <= '0;
            sout_q        <= load_first_d;
            sout_valid_q  <= 1'b1;
            frame_start_q <= 1'b1;
            frame_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q      <= ^load_data;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (bit_cnt_q == LAST_CNT) begin
`ifdef PISO_PARITY_EN
                        state_q       <= PARITY;
                        sout_q        <= parity_q;
                        sout_valid_q  <= 1'b1;
                        frame_start_q <= 1'b0;
                        frame_last_q  <= 1'b1;
`else
                        state_q       <= IDLE;
                        bit_cnt_q     <= '0;
                        sout_q        <= 1'b0;
                        sout_valid_q  <= 1'b0;
                        frame_start_q <= 1'b0;
                        frame_last_q  <= 1'b0;
`endif
                    end else begin
                        bit_cnt_q     <= bit_cnt_q + CNT_W'(1);
                        shreg_q       <= shift_rest_d;
                        sout_q        <= shift_first_d;
                        sout_valid_q  <= 1'b1;
                        frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
                        frame_last_q  <= 1'b0;
`else
                        frame_last_q  <= (bit_cnt_q == PRE_LAST_CNT);
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state_q       <= IDLE;
                    bit_cnt_q     <= '0;
                    sout_q        <= 1'b0;
                    sout_valid_q  <= 1'b0;
                    frame_start_q <= 1'b0;
                    frame_last_q  <= 1'b0;
                end
`endif
                default: begin
                    state_q       <= IDLE;
                    bit_cnt_q     <= '0;
                    sout_q        <= 1'b0;
                    sout_valid_q  <= 1'b0;
                    frame_start_q <= 1'b0;
                    frame_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign busy        = (state_q != IDLE);

endmodule
